// File: rtl/add_round_key_pipe.sv
// add_round_key_pipe
//
// Registered, flow-controlled round-key XOR stage for an iterative AES-128
// datapath. A bank of NUM_KEYS round keys is loaded through a write port.
// Each accepted state word is XORed with the key selected by the index that
// travels with it, and the result is presented through a valid/ready output.
//
// Optional build macro:
//   ARK_PIPE2_EN - adds a second register stage (latency 2). Stage 1 captures
//                  the state word and the key looked up at acceptance. Stage 2
//                  captures the XOR.
//
// Parameters:
//   DATA_W   - state/key width in bits
//   NUM_KEYS - number of round-key slots
//   KIDX_W   - key index width; 2**KIDX_W must be >= NUM_KEYS
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset; clears keys and the pipeline
//   key_we    - round-key write strobe
//   key_widx  - slot written when key_we=1 (out-of-range writes are dropped)
//   key_wdata - round key value
//   in_valid  - input word valid
//   in_ready  - stage can accept input this cycle
//   in_data   - state word
//   in_kidx   - round-key slot to apply
//   out_valid - output register holds a result
//   out_ready - downstream accepts output
//   out_data  - in_data ^ key[in_kidx] (in_data unchanged for an invalid index)
//   err_kidx  - one-cycle pulse when a word with in_kidx >= NUM_KEYS first
//               appears at the output

module add_round_key_pipe #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned NUM_KEYS = 11,
    parameter int unsigned KIDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_we,
    input  logic [KIDX_W-1:0] key_widx,
    input  logic [DATA_W-1:0] key_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KIDX_W-1:0] in_kidx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err_kidx
);

    // ------------------------------------------------------------------
    // Round-key bank
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] key_q [NUM_KEYS];

    // Slot-by-slot compare rather than a direct array index so an
    // out-of-range key_widx simply matches nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                key_q[i] <= '0;
            end
        end else if (key_we) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (key_widx == KIDX_W'(i)) begin
                    key_q[i] <= key_wdata;
                end
            end
        end
    end

    // Lookup reads the registered bank, so a same-cycle write to the selected
    // slot is not visible until the next word. An index with no matching slot
    // selects an all-zero key and is flagged.
    logic [DATA_W-1:0] key_sel;
    logic              kidx_hit;

    always_comb begin
        key_sel  = '0;
        kidx_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (in_kidx == KIDX_W'(i)) begin
                key_sel  = key_q[i];
                kidx_hit = 1'b1;
            end
        end
    end

    logic in_fire;
    assign in_fire = in_valid && in_ready;

`ifdef ARK_PIPE2_EN
    // ------------------------------------------------------------------
    // Two-stage elastic pipeline
    // ------------------------------------------------------------------
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [DATA_W-1:0] s1_key_q;
    logic              s1_err_q;
    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_data_q;
    logic              s2_err_q;

    logic s2_ready;
    logic s1_adv;

    // Stage 2 can take a word when it is empty or draining this cycle.
    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_ready;
    assign in_ready = !s1_valid_q || s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_key_q   <= '0;
            s1_err_q   <= 1'b0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
            s1_data_q  <= in_data;
            s1_key_q   <= key_sel;
            s1_err_q   <= !kidx_hit;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            // err is only raised on the cycle a word lands in stage 2, so it
            // never repeats while that word is stalled.
            s2_err_q <= 1'b0;
            if (s1_adv) begin
                s2_valid_q <= 1'b1;
                s2_data_q  <= s1_data_q ^ s1_key_q;
                s2_err_q   <= s1_err_q;
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign err_kidx  = s2_err_q;
`else
    // ------------------------------------------------------------------
    // Single output register
    // ------------------------------------------------------------------
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              err_q;

    // Accept when empty or when the held word drains this cycle.
    assign in_ready = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            // err is only raised on the load cycle, so it never repeats while
            // the word is stalled.
            err_q <= 1'b0;
            if (in_fire) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data ^ key_sel;
                err_q       <= !kidx_hit;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err_kidx  = err_q;
`endif

endmodule

// File: tb/tb_add_round_key_pipe.sv
// Self-checking bench for add_round_key_pipe. Random and directed traffic is
// scored against a key-bank array plus an in-order queue of expected results.

module tb_add_round_key_pipe;

    localparam int unsigned DATA_W   = 128;
    localparam int unsigned NUM_KEYS = 11;
    localparam int unsigned KIDX_W   = 4;
`ifdef ARK_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              key_we;
    logic [KIDX_W-1:0] key_widx;
    logic [DATA_W-1:0] key_wdata;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [KIDX_W-1:0] in_kidx;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              err_kidx;

    add_round_key_pipe #(
        .DATA_W   (DATA_W),
        .NUM_KEYS (NUM_KEYS),
        .KIDX_W   (KIDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_we    (key_we),
        .key_widx  (key_widx),
        .key_wdata (key_wdata),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_kidx   (in_kidx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_kidx  (err_kidx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    logic [DATA_W-1:0] keys_m [NUM_KEYS];
    exp_t              exp_q [$];
    logic              seen;
    int                nchk  = 0;
    int                nfail = 0;
    logic              s_out_valid;
    logic [DATA_W-1:0] s_out_data;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: inputs are already set (at posedge+1); sample mid-cycle,
    // score the handshakes, then advance to the next posedge+1.
    task automatic cycle();
        logic ir, ov, oe, in_hs, out_hs;
        logic [DATA_W-1:0] od;
        logic [DATA_W-1:0] k;
        exp_t e;
        #2;
        ir = in_ready;
        ov = out_valid;
        od = out_data;
        oe = err_kidx;
        s_out_valid = ov;
        s_out_data  = od;
        in_hs  = in_valid && ir;
        out_hs = ov && out_ready;

        if (out_ready) check("ready_when_drained", ir, 1'b1);
`ifndef ARK_PIPE2_EN
        check("ready_rule", ir, !ov || out_ready);
`endif
        if (exp_q.size() == 0 || LAT == 1) check("out_valid", ov, exp_q.size() != 0);
        if (ov && exp_q.size() > 0) begin
            check("out_data", od, exp_q[0].data);
            check("err_kidx", oe, exp_q[0].err && !seen);
            seen = 1'b1;
        end else begin
            check("err_idle", oe, 1'b0);
        end

        if (out_hs && exp_q.size() > 0) begin
            exp_q.delete(0);
            seen = 1'b0;
        end
        if (in_hs) begin
            k = (int'(in_kidx) < NUM_KEYS) ? keys_m[in_kidx] : '0;
            e.data = in_data ^ k;
            e.err  = int'(in_kidx) >= NUM_KEYS;
            exp_q.push_back(e);
        end
        check("inflight", exp_q.size() <= LAT, 1'b1);
        if (key_we && int'(key_widx) < NUM_KEYS) keys_m[key_widx] = key_wdata;

        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        key_we    = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input int kidx);
        in_valid = 1'b1;
        in_data  = d;
        in_kidx  = KIDX_W'(kidx);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic write_key(input int idx, input logic [DATA_W-1:0] k);
        key_we    = 1'b1;
        key_widx  = KIDX_W'(idx);
        key_wdata = k;
        cycle();
        key_we = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) cycle();
        check("drain_empty", exp_q.size(), 0);
        cycle();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_KEYS; i++) keys_m[i] = '0;
        exp_q.delete();
        seen = 1'b0;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        key_we    = 1'b0;
        key_widx  = '0;
        key_wdata = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_kidx   = '0;
        out_ready = 1'b1;
        model_reset();
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_err", err_kidx, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known-answer vector and latency
        write_key(0, 128'h000102030405060708090a0b0c0d0e0f);
        send(128'h00112233445566778899aabbccddeeff, 0);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_out_valid && n < 10);
        check("latency", n, LAT);
        check("kat", s_out_data, 128'h00102030405060708090a0b0c0d0e0f0);
        drain();

        // Distinct keys in all slots, then back-to-back stream
        for (int i = 0; i < NUM_KEYS; i++) write_key(i, rnd128());
        for (int i = 0; i < NUM_KEYS; i++) send(rnd128(), i);
        drain();

        // Stall with pending input
        send(rnd128(), 4);
        in_valid  = 1'b1;
        in_data   = rnd128();
        in_kidx   = 4'd7;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        check("stall_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        drain();

        // Same-cycle key write and lookup of slot 3
        key_we    = 1'b1;
        key_widx  = 4'd3;
        key_wdata = rnd128();
        send(rnd128(), 3);
        key_we = 1'b0;
        send(rnd128(), 3);
        drain();

        // Out-of-range index and out-of-range key write
        send(rnd128(), 12);
        drain();
        write_key(15, rnd128());
        write_key(11, rnd128());
        for (int i = 0; i < NUM_KEYS; i++) send(rnd128(), i);
        drain();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rnd128();
            in_kidx   = KIDX_W'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            key_we    = ($urandom_range(0, 3) == 0);
            key_widx  = KIDX_W'($urandom_range(0, 15));
            key_wdata = rnd128();
            cycle();
        end
        drain();

        // Asynchronous reset with a word held
        send(rnd128(), 2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("pre_reset_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_data", out_data, '0);
        check("async_rst_err", err_kidx, 1'b0);
        model_reset();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_KEYS; i++) send(rnd128(), i);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/add_round_key_pipe.md
Name: add_round_key_pipe

Overview:
- Registered, flow-controlled successor to the combinational round-key XOR stage.
- Holds a bank of NUM_KEYS round keys, loaded through a write port.
- Each accepted data word is XORed with the round key selected by an index carried alongside it.
- Sits between the round-function stages and the key expansion unit, so one instance serves every round of an iterative AES-128 datapath.

Parameters:
DATA_W, 128, state/key width in bits
NUM_KEYS, 11, number of round-key slots (AES-128: rounds 0..10)
KIDX_W, 4, index width; must satisfy 2**KIDX_W >= NUM_KEYS

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_we  in  1  round-key write strobe
key_widx  in  KIDX_W  slot written when key_we=1
key_wdata  in  DATA_W  round key value
in_valid  in  1  input word valid
in_ready  out  1  stage can accept input this cycle
in_data  in  DATA_W  state word
in_kidx  in  KIDX_W  round-key slot to apply
out_valid  out  1  output register holds a result
out_ready  in  1  downstream accepts output
out_data  out  DATA_W  in_data ^ key[in_kidx]
err_kidx  out  1  one-cycle pulse: accepted word had in_kidx >= NUM_KEYS

Behaviour:
- Reset (async assert, sync release internally not required): all key slots = 0, out_valid=0, out_data=0, err_kidx=0. Reset mid-transfer discards the held word. Key bank contents are lost.
- Transfer rules:
  - Input handshake completes when in_valid && in_ready.
  - Output handshake completes when out_valid && out_ready.
- Readiness: in_ready = !out_valid || out_ready. A new word is accepted in the same cycle the held word drains, giving full throughput of 1 word/cycle.
- Latency: 1 cycle. A word accepted at edge N appears on out_data with out_valid=1 after edge N.
- Stall hold: while out_valid && !out_ready, out_data and out_valid must not change. Input values are ignored while in_ready=0.
- Drain: out_valid clears on an output handshake with no simultaneous input handshake.
- Key writes:
  - Take effect at the clock edge.
  - A same-cycle read of the same slot uses the pre-write (old) key.
  - key_we with key_widx >= NUM_KEYS is ignored; no error is flagged.
- Out-of-range in_kidx (>= NUM_KEYS):
  - Word is still accepted.
  - out_data = in_data, i.e. XOR with zero.
  - err_kidx pulses high for exactly the cycle out_valid first asserts for that word.
- err_kidx is otherwise 0. It does not repeat during stalls.
- Arithmetic: bitwise XOR over the full DATA_W; no width extension.

Optional Feature:
ARK_PIPE2_EN
- Defined:
  - A second register stage is added; latency becomes 2 cycles.
  - Stage 1 registers in_data and the looked-up key; stage 2 registers the XOR.
  - Each stage has its own valid bit and propagates with elastic ready: stage1 advances when stage2 is empty or draining.
  - in_ready = !v1 || stage1 advancing. Throughput remains 1 word/cycle.
  - The key lookup happens at acceptance; later key writes do not affect words already in flight.
  - err_kidx pulses when the offending word first appears at the output.
- Not defined: single-stage behaviour as specified above.

Test Plan:
- Reset, then write slot 0 = 0x000102030405060708090a0b0c0d0e0f. Send in_data = 0x00112233445566778899aabbccddeeff with kidx 0, out_ready=1 -> out_data = 0x00102030405060708090a0b0c0d0e0f0 one cycle later (two with ARK_PIPE2_EN).
- Load slots 0..10 with distinct keys. Stream 11 back-to-back words with kidx 0..10, out_ready=1 -> in_ready stays 1, and 11 consecutive out_valid cycles each equal word^key[i].
- Hold out_ready=0 for 5 cycles with a word held and in_valid=1 -> in_ready=0 and out_data stable. Release -> no word is lost or duplicated, and order is preserved.
- In the same cycle, write slot 3 = K_new and accept a word with kidx 3 -> output uses K_old. The next word with kidx 3 uses K_new.
- Send in_kidx=12 with NUM_KEYS=11 -> out_data = in_data, err_kidx = 1 for a single cycle. A key write to idx 15 leaves all slots unchanged.
- Assert rst_n=0 while out_valid=1 -> out_valid=0 and out_data=0 immediately (asynchronous). Key slots read back as 0 (XOR yields in_data).
